// File: rtl/vsmac_sequencer_pkg.sv
// Shared types and sizing for the vector-scalar MAC sequencer and its result serializer.
package vsmac_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  localparam int DEF_SIZE           = 6;
  localparam int ELEM_W             = 8;
  localparam int DEF_ACCUMULATIONS  = 3;
  localparam int DEF_RESULT_LATENCY = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_CNT_W = cnt_w(DEF_ACCUMULATIONS);
  localparam int LAT_CNT_W  = cnt_w(DEF_RESULT_LATENCY);
  localparam int IDX_CNT_W  = cnt_w(DEF_SIZE);

endpackage

// File: rtl/vsmac_result_serializer.sv
// Holds the captured MAC result vector and streams it out one element per handshake.
module vsmac_result_serializer
  import vsmac_sequencer_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = ELEM_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [WIDTH*SIZE-1:0] mac_out,
  input  logic                  res_ready,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_last,
  output logic                  done
);

  logic [WIDTH*SIZE-1:0] result;
  logic [IDX_CNT_W-1:0]  idx;
  logic [IDX_CNT_W-1:0]  idx_next;
  logic                  handshake;

  assign handshake = res_valid && res_ready;
  assign done      = handshake && res_last;
  assign idx_next  = idx + IDX_CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      idx       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else if (load) begin
      result    <= mac_out;
      idx       <= '0;
      res_valid <= 1'b1;
      res_data  <= mac_out[WIDTH-1:0];
      res_last  <= (SIZE == 1);
    end else if (handshake) begin
      if (res_last) begin
        idx       <= '0;
        res_valid <= 1'b0;
        res_data  <= '0;
        res_last  <= 1'b0;
      end else begin
        // res_data/res_last are precomputed for the next element so they stay registered
        idx      <= idx_next;
        res_data <= result[WIDTH*int'(idx_next) +: WIDTH];
        res_last <= (idx_next == IDX_CNT_W'(SIZE - 1));
      end
    end
  end

endmodule

// File: rtl/vsmac_sequencer.sv
// Sequences operand beats into the MAC array, waits out its latency, then hands the result
// vector to the serializer.
//   state   | meaning
//   IDLE    | no job; waits for in_valid (beat not consumed)
//   CLEAR   | one-cycle mac_clear pulse, beat counter reset
//   FEED    | accepts ACCUMULATIONS operand beats
//   WAIT    | RESULT_LATENCY cycles for mac_out to settle
//   CAPTURE | serializer loads mac_out
//   DRAIN   | result elements streamed out
module vsmac_sequencer
  import vsmac_sequencer_pkg::*;
#(
  parameter int SIZE           = DEF_SIZE,
  parameter int WIDTH          = ELEM_W,
  parameter int ACCUMULATIONS  = DEF_ACCUMULATIONS,
  parameter int RESULT_LATENCY = DEF_RESULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*SIZE-1:0] in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic [WIDTH*SIZE-1:0] mac_a,
  output logic [WIDTH-1:0]      mac_b,
  input  logic [WIDTH*SIZE-1:0] mac_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_last,
  output logic                  busy
);

  state_t                state, next_state;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic                  accept;
  logic                  last_beat;
  logic                  drain_done;

  assign in_ready  = (state == ST_FEED);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == BEAT_CNT_W'(ACCUMULATIONS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (in_valid) next_state = ST_CLEAR;
      ST_CLEAR:   next_state = ST_FEED;
      ST_FEED:    if (last_beat) next_state = ST_WAIT;
      ST_WAIT:    if (lat_cnt == '0) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_DRAIN;
      ST_DRAIN:   if (drain_done) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_clear  <= 1'b0;
      mac_enable <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      busy       <= 1'b0;
      beat_cnt   <= '0;
      lat_cnt    <= '0;
    end else begin
      mac_clear  <= (next_state == ST_CLEAR);
      mac_enable <= accept;
      busy       <= (next_state != ST_IDLE);
      if (accept) begin
        mac_a <= in_a;
        mac_b <= in_b;
      end
      if (state == ST_CLEAR)  beat_cnt <= '0;
      else if (accept)        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      // the last enable cycle is already the first WAIT cycle, hence the -1
      if (last_beat)                              lat_cnt <= LAT_CNT_W'(RESULT_LATENCY - 1);
      else if (state == ST_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LAT_CNT_W'(1);
    end
  end

  vsmac_result_serializer #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (state == ST_CAPTURE),
    .mac_out   (mac_out),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_last  (res_last),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_vsmac_sequencer.sv
// Directed and randomized jobs against a behavioural MAC array model and per-lane dot-product reference.
module tb_vsmac_sequencer;
  import vsmac_sequencer_pkg::*;

  localparam int SIZE  = 6;
  localparam int WIDTH = 8;
  localparam int ACC   = 3;
  localparam int RL    = 2;
  localparam int VW    = WIDTH * SIZE;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    in_a;
  logic [WIDTH-1:0] in_b;
  logic             mac_clear;
  logic             mac_enable;
  logic [VW-1:0]    mac_a;
  logic [WIDTH-1:0] mac_b;
  logic [VW-1:0]    mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_last;
  logic             busy;

  vsmac_sequencer #(
    .SIZE           (SIZE),
    .WIDTH          (WIDTH),
    .ACCUMULATIONS  (ACC),
    .RESULT_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mac_clear  (mac_clear),
    .mac_enable (mac_enable),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_out    (mac_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: acc updates one edge after an enable cycle, then RL-1 more delay stages.
  logic [VW-1:0] acc_vec;
  logic [VW-1:0] dly [RL-1];
  bit            use_force = 1'b0;
  logic [VW-1:0] force_val = '0;

  always @(posedge clk or negedge reset_n) begin
    logic [VW-1:0] nxt;
    if (!reset_n) begin
      acc_vec <= '0;
      for (int k = 0; k < RL - 1; k++) dly[k] <= '0;
    end else begin
      nxt = acc_vec;
      if (mac_clear) nxt = '0;
      else if (mac_enable)
        for (int i = 0; i < SIZE; i++)
          nxt[i*WIDTH +: WIDTH] = acc_vec[i*WIDTH +: WIDTH] + mac_a[i*WIDTH +: WIDTH] * mac_b;
      acc_vec <= nxt;
      dly[0]  <= acc_vec;
      for (int k = 1; k < RL - 1; k++) dly[k] <= dly[k-1];
    end
  end

  assign mac_out = use_force ? force_val : dly[RL-2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " mac_clear"},  64'(mac_clear),  64'(0));
    chk({tag, " mac_enable"}, 64'(mac_enable), 64'(0));
    chk({tag, " mac_a"},      64'(mac_a),      64'(0));
    chk({tag, " mac_b"},      64'(mac_b),      64'(0));
    chk({tag, " res_valid"},  64'(res_valid),  64'(0));
    chk({tag, " res_data"},   64'(res_data),   64'(0));
    chk({tag, " res_last"},   64'(res_last),   64'(0));
    chk({tag, " busy"},       64'(busy),       64'(0));
    chk({tag, " in_ready"},   64'(in_ready),   64'(0));
  endtask

  logic [VW-1:0]    job_a [ACC];
  logic [WIDTH-1:0] job_b [ACC];
  int  vmode = 0;
  int  rmode = 0;
  bit  vpat[$];
  bit  keep_valid = 1'b0;

  task automatic set_job_ones();
    for (int j = 0; j < ACC; j++) begin
      for (int i = 0; i < SIZE; i++) job_a[j][i*WIDTH +: WIDTH] = WIDTH'(1);
      job_b[j] = WIDTH'(j + 2);
    end
  endtask

  task automatic set_job_random();
    for (int j = 0; j < ACC; j++) begin
      job_a[j] = VW'({$urandom, $urandom});
      job_b[j] = WIDTH'($urandom);
    end
  endtask

  task automatic run_job(input string tag, input bit check_len);
    int cyc = 0, beats = 0, idx = 0, clears = 0, enables = 0, stall = 0;
    int clear_at = -1, done_at = -1;
    bit prev_acc = 1'b0, prev_stall = 1'b0, done = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    int exp_el [SIZE];
    for (int i = 0; i < SIZE; i++) begin
      int s = 0;
      for (int j = 0; j < ACC; j++)
        s += int'(job_a[j][i*WIDTH +: WIDTH]) * int'(job_b[j]);
      exp_el[i] = use_force ? int'(force_val[i*WIDTH +: WIDTH]) : (s % 256);
    end
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, " idle busy"},     64'(busy),     64'(0));
        chk({tag, " idle in_ready"}, 64'(in_ready), 64'(0));
      end
      if (mac_clear) begin
        clears++;
        if (clear_at < 0) clear_at = cyc;
      end
      chk({tag, " enable after accept"}, 64'(mac_enable), 64'(prev_acc));
      if (mac_enable) begin
        if (enables < ACC) begin
          chk({tag, " mac_a"}, 64'(mac_a), 64'(job_a[enables]));
          chk({tag, " mac_b"}, 64'(mac_b), 64'(job_b[enables]));
        end
        enables++;
      end else if (enables > 0 && enables <= ACC) begin
        chk({tag, " mac_a hold"}, 64'(mac_a), 64'(job_a[enables-1]));
      end
      if (clear_at > 0) chk({tag, " busy"}, 64'(busy), 64'(1));
      if (beats == ACC) chk({tag, " no overlap"}, 64'(in_ready), 64'(0));
      if (beats < ACC) begin
        if (in_ready) begin
          if (vmode == 0)      in_valid = 1'b1;
          else if (vmode == 1) in_valid = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
          else                 in_valid = 1'($urandom_range(0, 1));
        end else in_valid = 1'b1;
        in_a = job_a[beats];
        in_b = job_b[beats];
      end else in_valid = keep_valid;
      prev_acc = in_valid && in_ready;
      if (prev_acc) beats++;
      if (rmode == 0)      res_ready = 1'b1;
      else if (rmode == 1) res_ready = !(idx == 1 && stall < 5);
      else                 res_ready = 1'($urandom_range(0, 1));
      if (res_valid) begin
        if (idx < SIZE) begin
          chk({tag, " res_data"}, 64'(res_data), 64'(exp_el[idx]));
          chk({tag, " res_last"}, 64'(res_last), 64'(idx == SIZE - 1));
        end
        if (prev_stall) begin
          chk({tag, " stable data"}, 64'(res_data), 64'(prev_data));
          chk({tag, " stable last"}, 64'(res_last), 64'(prev_last));
        end
        if (!res_ready) begin
          stall++;
          prev_stall = 1'b1;
          prev_data  = res_data;
          prev_last  = res_last;
        end else begin
          prev_stall = 1'b0;
          idx++;
          if (idx == SIZE) begin
            done    = 1'b1;
            done_at = cyc;
          end
        end
      end else prev_stall = 1'b0;
    end
    chk({tag, " completed"},   64'(done),     64'(1));
    chk({tag, " clear pulses"}, 64'(clears),  64'(1));
    chk({tag, " enable count"}, 64'(enables), 64'(ACC));
    chk({tag, " clear cycle"},  64'(clear_at), 64'(2));
    if (check_len)
      chk({tag, " job length"}, 64'(done_at - clear_at + 1), 64'(1 + ACC + RL + 1 + SIZE));
    if (rmode == 1) chk({tag, " stall cycles"}, 64'(stall), 64'(5));
  endtask

  initial begin
    int beats;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;

    set_job_ones();
    run_job("basic", 1'b1);

    use_force = 1'b1;
    force_val = 48'h060504030201;
    run_job("order", 1'b1);
    use_force = 1'b0;

    vmode = 1;
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job("bubbles", 1'b0);
    vmode = 0;

    rmode = 1;
    run_job("backpressure", 1'b0);
    rmode = 0;

    // reset in the middle of FEED, after two accepted beats
    set_job_random();
    for (int j = 0; j < ACC; j++) job_a[j][7:0] = 8'hA5;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = job_a[beats];
      in_b     = job_b[beats];
      if (in_ready) beats++;
    end
    chk("midfeed beats", 64'(beats), 64'(2));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset("midfeed reset");
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_job_ones();
    run_job("after reset", 1'b1);

    keep_valid = 1'b1;
    run_job("b2b first", 1'b1);
    keep_valid = 1'b0;
    set_job_random();
    run_job("b2b second", 1'b1);

    vmode = 2;
    rmode = 2;
    for (int n = 0; n < 4; n++) begin
      set_job_random();
      run_job($sformatf("random%0d", n), 1'b0);
    end

    @(negedge clk);
    chk("final busy",      64'(busy),      64'(0));
    chk("final res_valid", 64'(res_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
